// File: rtl/restoring_div_ctrl.sv
// Sequential 8-bit unsigned restoring divider: one shift/subtract per SUB cycle,
// plus a RESTORE cycle for each zero quotient bit. Start/busy/done handshake.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; results and div_by_zero hold
// SUB     | shift A:Q left one bit, trial subtract M, set quotient bit
// RESTORE | trial went negative; add M back to A
// DONE    | results valid, done high for this single cycle
module restoring_div_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero,
  output logic [7:0] quotient,
  output logic [7:0] remainder
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SUB     = 2'd1,
    S_RESTORE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  a_q, a_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  m_q, m_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  quot_q, quot_d;
  logic [7:0]  rem_q, rem_d;
  logic        dbz_q, dbz_d;
  logic [8:0]  diff;
  logic [8:0]  sum;
  logic [7:0]  q_shift;

  // A[8] is always 0 entering SUB, so only A[7:0] takes part in the shift.
  assign diff    = {a_q[7:0], q_q[7]} - {1'b0, m_q};
  assign sum     = a_q + {1'b0, m_q};
  assign q_shift = {q_q[6:0], ~diff[8]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (divisor != 8'd0) begin
            a_d     = 9'd0;
            q_d     = dividend;
            m_d     = divisor;
            cnt_d   = 3'd0;
            dbz_d   = 1'b0;
            state_d = S_SUB;
          end else begin
            quot_d  = 8'hFF;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_SUB: begin
        a_d = diff;
        q_d = q_shift;
        if (diff[8]) begin
          state_d = S_RESTORE;
        end else if (cnt_q == 3'd7) begin
          quot_d  = q_shift;
          rem_d   = diff[7:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_RESTORE: begin
        a_d = sum;
        if (cnt_q == 3'd7) begin
          quot_d  = q_q;
          rem_d   = sum[7:0];
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = S_SUB;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 9'd0;
      q_q     <= 8'd0;
      m_q     <= 8'd0;
      cnt_q   <= 3'd0;
      quot_q  <= 8'd0;
      rem_q   <= 8'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_SUB) || (state_q == S_RESTORE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Self-checking bench for restoring_div_ctrl: directed vector table, hand-built
// corner sequences and random divisions against an arithmetic reference.
module tb_restoring_div_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [7:0] quotient;
  logic [7:0] remainder;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  restoring_div_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  typedef struct {
    logic [7:0] dd;
    logic [7:0] dv;
    logic [7:0] exp_q;
    logic [7:0] exp_r;
    logic       exp_dbz;
    int         exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain division; one RESTORE cycle per zero quotient bit.
  task automatic model(input logic [7:0] dd, input logic [7:0] dv,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic dbz, output int lat);
    if (dv == 8'd0) begin
      q = 8'hFF; r = dd; dbz = 1'b1; lat = 0;
    end else begin
      q = dd / dv; r = dd % dv; dbz = 1'b0;
      lat = 8 + (8 - $countones(q));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Accept one division, optionally pulse a second start while busy at cycle inj.
  task automatic run_div(input string name, input logic [7:0] dd, input logic [7:0] dv,
                         input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                         input int elat, input int inj);
    int j;
    int busy_cnt;
    @(negedge clk);
    start = 1'b1; dividend = dd; divisor = dv;
    @(posedge clk); #1;
    start = 1'b0;
    j = 0; busy_cnt = 0;
    while (!done && j < 40) begin
      if (busy) busy_cnt++;
      if (j == inj) begin
        start = 1'b1; dividend = 8'd10; divisor = 8'd2;
      end
      @(posedge clk); #1;
      start = 1'b0;
      j++;
    end
    check({name, " latency"}, j, elat);
    check({name, " busy_cycles"}, busy_cnt, elat);
    check({name, " quotient"}, quotient, eq);
    check({name, " remainder"}, remainder, er);
    check({name, " div_by_zero"}, div_by_zero, edbz);
    @(posedge clk); #1;
    check({name, " done_one_cycle"}, done, 0);
    check({name, " result_hold"}, {quotient, remainder}, {eq, er});
  endtask

  initial begin
    logic [7:0] mq, mr, rd, rv;
    logic       mdbz;
    int         mlat;
    int         dones;

    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset dbz", div_by_zero, 0);
    check("reset quotient", quotient, 0);
    check("reset remainder", remainder, 0);

    vecs.push_back('{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 13});
    vecs.push_back('{8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 8});
    vecs.push_back('{8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 16});
    vecs.push_back('{8'd200, 8'd0,   8'hFF,  8'd200, 1'b1, 0});
    vecs.push_back('{8'd10,  8'd2,   8'd5,   8'd0,   1'b0, 14});
    vecs.push_back('{8'd180, 8'd11,  8'd16,  8'd4,   1'b0, 15});
    vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0, 16});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 15});
    vecs.push_back('{8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 16});
    foreach (vecs[i])
      run_div($sformatf("vec%0d %0d/%0d", i, vecs[i].dd, vecs[i].dv), vecs[i].dd, vecs[i].dv,
              vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dbz, vecs[i].exp_lat, -1);

    // div_by_zero must clear on the next accepted nonzero-divisor start
    run_div("dbz then", 8'd0, 8'd0, 8'hFF, 8'd0, 1'b1, 0, -1);
    run_div("77/3 ignore", 8'd77, 8'd3, 8'd25, 8'd2, 1'b0, 13, 4);
    run_div("10/2 after", 8'd10, 8'd2, 8'd5, 8'd0, 1'b0, 14, -1);

    // Reset mid-operation aborts without a done pulse and clears results
    @(negedge clk);
    start = 1'b1; dividend = 8'd180; divisor = 8'd11;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort dbz", div_by_zero, 0);
    dones = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort no_done", dones, 0);
    check("abort stays_idle", busy, 0);
    run_div("180/11 rerun", 8'd180, 8'd11, 8'd16, 8'd4, 1'b0, 15, -1);

    // start held high: re-accepted one cycle after done
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd7;
    dones = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
    end
    check("held done_seen", done, 1);
    @(posedge clk); #1;
    check("held idle_gap", busy, 0);
    @(posedge clk); #1;
    check("held reaccept", busy, 1);
    start = 1'b0;
    do_reset();

    for (int t = 0; t < 150; t++) begin
      rd = 8'($urandom);
      rv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      model(rd, rv, mq, mr, mdbz, mlat);
      run_div($sformatf("rand %0d/%0d", rd, rv), rd, rv, mq, mr, mdbz, mlat, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
